regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 152 +++++++++++++++
 tb/tb_regfile_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: four-state (IDLE/READ/EXEC/WRITE) instruction sequencer
// driving an external combinational-read register file.
// Optional feature: define REGFILE_SEQUENCER_MUL_EN to build the MUL opcode;
// without it opcode 6 is treated as illegal and no multiplier exists.
module regfile_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [19:0] instr,
  output logic        instr_ready,
  output logic [3:0]  read_reg_addr_1,
  output logic [3:0]  read_reg_addr_2,
  input  logic [15:0] read_data_1,
  input  logic [15:0] read_data_2,
  output logic        regWrite,
  output logic [3:0]  write_reg_addr,
  output logic [15:0] write_data,
  output logic        clear_regs,
  output logic [15:0] display_data,
  output logic        display_valid,
  output logic        done,
  output logic        illegal_op
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SUBI = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_CLR  = 4'd7;
  localparam logic [3:0] OP_DISP = 4'd8;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  opc_q, opc_d, dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic [7:0]  imm_q, imm_d;
  logic [15:0] op1_q, op1_d, op2_q, op2_d, result_q, result_d, disp_q, disp_d;
  logic [15:0] imm_sext;
  logic        is_write_op, is_illegal, in_write;

  assign imm_sext = {{8{imm_q[7]}}, imm_q};

  // Decode legality of the latched opcode; MUL only exists when built in.
  always_comb begin
    is_write_op = 1'b0;
    is_illegal  = 1'b0;
    case (opc_q)
      OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: is_write_op = 1'b1;
`ifdef REGFILE_SEQUENCER_MUL_EN
      OP_MUL:                                    is_write_op = 1'b1;
`else
      OP_MUL:                                    is_illegal  = 1'b1;
`endif
      OP_NOP, OP_CLR, OP_DISP:                   ;
      default:                                   is_illegal  = 1'b1;
    endcase
  end

  // Next-state, instruction latch, operand capture and result computation.
  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    dest_d   = dest_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    imm_d    = imm_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    disp_d   = disp_q;
    case (state_q)
      IDLE: if (instr_valid) begin
        opc_d   = instr[19:16];
        dest_d  = instr[15:12];
        src1_d  = instr[11:8];
        src2_d  = instr[7:4];
        imm_d   = instr[7:0];
        state_d = READ;
      end
      READ: begin
        // Operands are sampled before any write of this instruction, so
        // dest==src always sees the old register value.
        op1_d   = read_data_1;
        op2_d   = read_data_2;
        state_d = EXEC;
      end
      EXEC: begin
        case (opc_q)
          OP_LOAD: result_d = imm_sext;
          OP_ADD:  result_d = op1_q + op2_q;
          OP_ADDI: result_d = op1_q + imm_sext;
          OP_SUB:  result_d = op1_q - op2_q;
          OP_SUBI: result_d = op1_q - imm_sext;
`ifdef REGFILE_SEQUENCER_MUL_EN
          OP_MUL:  result_d = op1_q * op2_q;
`endif
          default: result_d = result_q;
        endcase
        // Load the display register now so the data is valid alongside
        // its strobe in WRITE.
        if (opc_q == OP_DISP) disp_d = op1_q;
        state_d = WRITE;
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      opc_q    <= '0;
      dest_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      imm_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      dest_q   <= dest_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      imm_q    <= imm_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      disp_q   <= disp_d;
    end
  end

  assign in_write        = (state_q == WRITE);
  assign instr_ready     = (state_q == IDLE);
  assign read_reg_addr_1 = (state_q == READ) ? src1_q : 4'd0;
  assign read_reg_addr_2 = (state_q == READ) ? src2_q : 4'd0;
  assign regWrite        = in_write && is_write_op;
  assign write_reg_addr  = regWrite ? dest_q : 4'd0;
  assign write_data      = regWrite ? result_q : 16'd0;
  assign clear_regs      = in_write && (opc_q == OP_CLR);
  assign display_valid   = in_write && (opc_q == OP_DISP);
  assign display_data    = disp_q;
  assign done            = in_write;
  assign illegal_op      = in_write && is_illegal;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: scoreboard bench with a behavioural register file.
module tb_regfile_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [19:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  read_reg_addr_1, read_reg_addr_2, write_reg_addr;
  logic [15:0] read_data_1, read_data_2, write_data, display_data;
  logic        regWrite, clear_regs, display_valid, done, illegal_op;

  always #5 clock = ~clock;

  regfile_sequencer dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .read_reg_addr_1(read_reg_addr_1),
    .read_reg_addr_2(read_reg_addr_2), .read_data_1(read_data_1),
    .read_data_2(read_data_2), .regWrite(regWrite),
    .write_reg_addr(write_reg_addr), .write_data(write_data),
    .clear_regs(clear_regs), .display_data(display_data),
    .display_valid(display_valid), .done(done), .illegal_op(illegal_op)
  );

  // Behavioural register file seen by the DUT, plus a bench-side backdoor.
  logic [15:0] rf [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;

  assign read_data_1 = rf[read_reg_addr_1];
  assign read_data_2 = rf[read_reg_addr_2];

  always @(posedge clock) begin
    if (poke_en) rf[poke_addr] <= poke_data;
    else if (clear_regs) for (int i = 0; i < 16; i++) rf[i] <= 16'd0;
    else if (regWrite) rf[write_reg_addr] <= write_data;
  end

  typedef struct {
    logic        we, clr, disp, ill;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdl [16];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Reference model: expected side effects of one instruction.
  function automatic exp_t predict(input logic [3:0] op, input logic [3:0] dest,
                                   input logic [3:0] s1, input logic [7:0] lo);
    exp_t        e;
    logic [15:0] a, b, si;
    logic [31:0] p;
    a  = mdl[s1];
    b  = mdl[lo[7:4]];
    si = {{8{lo[7]}}, lo};
    p  = {16'd0, a} * {16'd0, b};
    e.we = 1'b0; e.clr = 1'b0; e.disp = 1'b0; e.ill = 1'b0;
    e.addr = dest; e.data = 16'd0;
    case (op)
      4'd0: ;
      4'd1: begin e.we = 1'b1; e.data = si; end
      4'd2: begin e.we = 1'b1; e.data = a + b; end
      4'd3: begin e.we = 1'b1; e.data = a + si; end
      4'd4: begin e.we = 1'b1; e.data = a - b; end
      4'd5: begin e.we = 1'b1; e.data = a - si; end
`ifdef REGFILE_SEQUENCER_MUL_EN
      4'd6: begin e.we = 1'b1; e.data = p[15:0]; end
`else
      4'd6: e.ill = 1'b1;
`endif
      4'd7: e.clr = 1'b1;
      4'd8: begin e.disp = 1'b1; e.data = a; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    @(negedge clock);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    mdl[a] = d;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Offer one instruction, then keep instr_valid high with junk while busy
  // (must be ignored) and measure edges from acceptance to done.
  task automatic issue(input logic [3:0] op, input logic [3:0] dest,
                       input logic [3:0] s1, input logic [7:0] lo);
    exp_t e;
    int   lat;
    int   guard;
    bit   seen;
    guard = 0;
    @(negedge clock);
    while (!instr_ready && guard < 20) begin @(negedge clock); guard++; end
    chk("ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr = {op, dest, s1, lo};
    e = predict(op, dest, s1, lo);
    sb.push_back(e);
    if (e.we) mdl[dest] = e.data;
    if (e.clr) for (int i = 0; i < 16; i++) mdl[i] = 16'd0;
    @(posedge clock);
    lat = 1;
    seen = 1'b0;
    @(negedge clock);
    instr = 20'($urandom);
    while (!seen && lat < 10) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clock); lat++;
        @(negedge clock); instr = 20'($urandom);
      end
    end
    instr_valid = 1'b0;
    chk("latency", 32'(lat), 32'd3);
  endtask

  // Scoreboard monitor: every done pops one expectation; strobes without
  // done are errors.
  exp_t mon_e;
  always @(negedge clock) begin
    if (reset) begin
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("regWrite", 32'(regWrite), 32'(mon_e.we));
          chk("clear_regs", 32'(clear_regs), 32'(mon_e.clr));
          chk("display_valid", 32'(display_valid), 32'(mon_e.disp));
          chk("illegal_op", 32'(illegal_op), 32'(mon_e.ill));
          chk("excl", 32'($countones({regWrite, clear_regs, display_valid}) <= 1), 32'd1);
          if (mon_e.we) begin
            chk("write_reg_addr", 32'(write_reg_addr), 32'(mon_e.addr));
            chk("write_data", 32'(write_data), 32'(mon_e.data));
          end
          if (mon_e.disp) chk("display_data", 32'(display_data), 32'(mon_e.data));
        end
      end else if (regWrite || clear_regs || display_valid || illegal_op) begin
        chk("stray_strobe", 32'({regWrite, clear_regs, display_valid, illegal_op}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 16'd0;
    // Reset values.
    repeat (2) @(negedge clock);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_outs", 32'({regWrite, clear_regs, display_valid, done, illegal_op}), 32'd0);
    chk("rst_disp", 32'(display_data), 32'd0);
    chk("rst_wdata", 32'(write_data), 32'd0);
    reset = 1'b1;
    // Zero the environment register file through the backdoor.
    for (int i = 0; i < 16; i++) poke(4'(i), 16'd0);

    issue(4'd1, 4'd3, 4'd0, 8'h85);        // LOAD R3 = 0xFF85
    poke(4'd1, 16'hFFFF);
    poke(4'd2, 16'h0002);
    issue(4'd2, 4'd1, 4'd1, 8'h20);        // ADD R1 = R1 + R2 -> 0x0001
    issue(4'd3, 4'd9, 4'd1, 8'hFF);        // ADDI R9 = R1 + -1 -> 0x0000
    issue(4'd4, 4'd5, 4'd3, 8'h10);        // SUB R5 = R3 - R1 -> 0xFF84
    issue(4'd5, 4'd10, 4'd3, 8'h80);       // SUBI R10 = R3 - 0xFF80 -> 0x0005
    poke(4'd4, 16'h0300);
    poke(4'd5, 16'h0100);
    issue(4'd6, 4'd6, 4'd4, 8'h50);        // MUL R6 = R4 * R5
    issue(4'hC, 4'd2, 4'd1, 8'h12);        // illegal opcode
    issue(4'd0, 4'd2, 4'd1, 8'h12);        // NOP
    poke(4'd7, 16'h1234);
    issue(4'd8, 4'd0, 4'd7, 8'h00);        // DISPLAY R7 -> 0x1234
    issue(4'd1, 4'd8, 4'd0, 8'h01);        // LOAD R8 = 1
    chk("disp_hold", 32'(display_data), 32'h1234);
    issue(4'd7, 4'd0, 4'd0, 8'h00);        // CLEAR
    issue(4'd8, 4'd0, 4'd7, 8'h00);        // DISPLAY R7 -> 0x0000

    // Abandon a SUB with reset asserted during EXEC.
    @(negedge clock);
    instr_valid = 1'b1;
    instr = {4'd4, 4'd2, 4'd3, 8'h10};
    @(posedge clock);                      // accepted, READ
    @(negedge clock);
    instr_valid = 1'b0;
    @(posedge clock);                      // EXEC
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(instr_ready), 32'd1);
    chk("rst_mid_outs", 32'({regWrite, clear_regs, display_valid, done, illegal_op}), 32'd0);
    chk("rst_mid_disp", 32'(display_data), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    issue(4'd1, 4'd2, 4'd0, 8'h7F);        // LOAD R2 = 0x007F
    issue(4'd2, 4'd2, 4'd2, 8'h20);        // ADD R2 = R2 + R2 -> 0x00FE

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
